uart_rx_os: RTL

Oversampling UART receiver with configurable frame format and per-frame error reporting. It is the next-generation receiver for the `uart` subsystem. It adds the following over the current receiver:
- programmable oversampling ratio
- majority-vote bit sampling
- optional parity and one or two stop bits
- framing, parity and overrun flags
- optional break detection

It takes the already-synchronised line from `cdc_sync` and feeds the RX `fifo` over a valid/ready stream.

---
 rtl/uart_rx_os.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os - oversampling UART receiver.
//
// Receives one asynchronous frame at a time from an already-synchronised,
// idle-high serial line and presents each completed word on a single-entry
// valid/ready holding register. Each bit is decided by a 3-sample majority
// vote centred on its bit period. Parity (none/odd/even) and one or two stop
// bits are set by parameter. A parity error and a framing error are reported
// alongside every word. A one-cycle overrun pulse flags a completed frame
// that was dropped because the holding register was still full.
//
// Optional feature macro: UART_RX_BREAK_EN
//   defined   : an all-zero frame is a line break. The frame is not pushed,
//               o_break is raised and held until the line returns high.
//   undefined : o_break does not exist. A break is delivered as data 0 with
//               o_ferr = 1.
//
// Ports:
//   clk        in   sole clock
//   rstn       in   asynchronous active-low reset
//   i_rxs      in   synchronised serial line, idle high
//   o_tvalid   out  held word valid
//   i_tready   in   downstream accepts the held word
//   o_tdata    out  received data, LSB = first bit on the line
//   o_perr     out  parity error of the held word
//   o_ferr     out  framing error of the held word (a stop bit sampled low)
//   o_overrun  out  one-cycle pulse: a completed frame was dropped
//   o_break    out  break flag (only with UART_RX_BREAK_EN)
module uart_rx_os #(
    parameter int BAUD   = 9600,
    parameter int CLKF   = 100000000,
    parameter int DLEN   = 8,
    parameter int OSR    = 16,
    parameter int PARITY = 0,
    parameter int STOP   = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_rxs,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic [DLEN-1:0] o_tdata,
    output logic            o_perr,
    output logic            o_ferr,
    output logic            o_overrun
`ifdef UART_RX_BREAK_EN
    ,
    output logic            o_break
`endif
);

    localparam int DIV  = CLKF / (BAUD * OSR);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OSW  = $clog2(OSR);
    localparam int MID  = OSR / 2;

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_os: CLKF/(BAUD*OSR) must be at least 2");
    end
    if (OSR < 8 || OSR > 32 || (OSR % 2) != 0) begin : g_osr_chk
        $error("uart_rx_os: OSR must be even and within 8..32");
    end
    if (DLEN < 5 || DLEN > 9) begin : g_dlen_chk
        $error("uart_rx_os: DLEN must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2 || STOP < 1 || STOP > 2) begin : g_fmt_chk
        $error("uart_rx_os: PARITY must be 0..2 and STOP 1..2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    state_t            state_q, state_d;
    logic              rxs_prev_q, rxs_prev_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [OSW-1:0]    os_q, os_d;
    logic [1:0]        vote_q, vote_d;
    logic [3:0]        bit_q, bit_d;
    logic [DLEN-1:0]   shift_q, shift_d;
    logic              par_q, par_d;
    logic              ferr_acc_q, ferr_acc_d;
    logic              tvalid_q, tvalid_d;
    logic [DLEN-1:0]   tdata_q, tdata_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              overrun_q, overrun_d;
`ifdef UART_RX_BREAK_EN
    logic              stop_one_q, stop_one_d;
    logic              brk_q, brk_d;
    logic              frame_brk;
`endif
    logic              tick, maj, decide, done, push;
    logic              frame_perr, frame_ferr;

    always_comb begin
        state_d    = state_q;
        rxs_prev_d = i_rxs;
        div_d      = (div_q == DIVW'(DIV - 1)) ? '0 : div_q + 1'b1;
        os_d       = os_q;
        vote_d     = vote_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_acc_d = ferr_acc_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        done       = 1'b0;
        push       = 1'b0;
`ifdef UART_RX_BREAK_EN
        stop_one_d = stop_one_q;
        brk_d      = brk_q;
`endif
        // The divider restarts at 0 on the start edge, so the first tick
        // coincides with the edge and counts as tick 1 of the start bit.
        // os_q is therefore one behind the 1-based tick number: samples are
        // taken at os_q = MID-2, MID-1, MID and the vote is decided at MID.
        tick   = (div_q == '0);
        decide = tick && (os_q == OSW'(MID));
        maj    = ((vote_q + {1'b0, i_rxs}) >= 2'd2);

        if (tick) begin
            os_d = (os_q == OSW'(OSR - 1)) ? '0 : os_q + 1'b1;
            if (os_q == OSW'(MID - 2) || os_q == OSW'(MID - 1)) begin
                vote_d = vote_q + {1'b0, i_rxs};
            end else if (decide) begin
                vote_d = '0;
            end
        end

        frame_ferr = ferr_acc_q | ~maj;
        frame_perr = (PARITY == 0) ? 1'b0 : ((^shift_q ^ par_q) != (PARITY == 1));
`ifdef UART_RX_BREAK_EN
        frame_brk  = (shift_q == '0) && !par_q && !stop_one_q && !maj;
`endif

        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !i_rxs) begin
                    state_d = S_START;
                    div_d   = '0;
                    os_d    = '0;
                    vote_d  = '0;
                end
            end
            S_START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        bit_d      = '0;
                        par_d      = 1'b0;
                        ferr_acc_d = 1'b0;
`ifdef UART_RX_BREAK_EN
                        stop_one_d = 1'b0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[DLEN-1:1]};
                    if (bit_q == 4'(DLEN - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (decide) begin
                    par_d   = maj;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (bit_q == 4'(STOP - 1)) begin
                        // Back to IDLE at once so a start edge right after
                        // the stop-bit centre is not missed.
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d      = bit_q + 1'b1;
                        ferr_acc_d = ferr_acc_q | ~maj;
`ifdef UART_RX_BREAK_EN
                        stop_one_d = stop_one_q | maj;
`endif
                    end
                end
            end
`ifdef UART_RX_BREAK_EN
            S_BREAK: begin
                if (i_rxs) begin
                    brk_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        push = done;
`ifdef UART_RX_BREAK_EN
        if (done && frame_brk) begin
            push    = 1'b0;
            brk_d   = 1'b1;
            state_d = S_BREAK;
        end
`endif

        if (tvalid_q && i_tready) begin
            tvalid_d = 1'b0;
        end
        // A full register that is not being drained this cycle keeps its
        // word; the new frame is dropped and flagged.
        if (push) begin
            if (tvalid_q && !i_tready) begin
                overrun_d = 1'b1;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = shift_q;
                perr_d   = frame_perr;
                ferr_d   = frame_ferr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rxs_prev_q <= 1'b0;
            div_q      <= '0;
            os_q       <= '0;
            vote_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            stop_one_q <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rxs_prev_q <= rxs_prev_d;
            div_q      <= div_d;
            os_q       <= os_d;
            vote_q     <= vote_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_BREAK_EN
            stop_one_q <= stop_one_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign o_tvalid  = tvalid_q;
    assign o_tdata   = tdata_q;
    assign o_perr    = perr_q;
    assign o_ferr    = ferr_q;
    assign o_overrun = overrun_q;
`ifdef UART_RX_BREAK_EN
    assign o_break   = brk_q;
`endif

endmodule
